// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: EA generation, handshaked data-memory access with timeout, aligned/extended load return.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned accesses fail with resp_err instead of being force-aligned.
module load_store_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [XLEN-1:0]     req_base,
  input  logic [15:0]         req_disp,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [TAG_W-1:0]    req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                resp_valid,
  output logic                resp_we,
  output logic [TAG_W-1:0]    resp_rd,
  output logic [XLEN-1:0]     resp_data,
  output logic                resp_err
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               store_q, store_d;
  logic               signed_q, signed_d;
  logic [1:0]         sz_q, sz_d;
  logic [TAG_W-1:0]   rd_q, rd_d;
  logic [OFF_W-1:0]   off_q, off_d;

  logic               req_ready_d, mem_req_d, mem_we_d;
  logic [XLEN-1:0]    mem_addr_d, mem_wdata_d;
  logic [LANES-1:0]   mem_be_d;
  logic               resp_valid_d, resp_we_d, resp_err_d;
  logic [TAG_W-1:0]   resp_rd_d;
  logic [XLEN-1:0]    resp_data_d;

  // Effective address and lane placement of the incoming request
  logic [15:0]        disp_eff;
  logic [XLEN-1:0]    ea;
  logic [1:0]         sz_l2;
  logic [OFF_W-1:0]   off_raw, size_mask, off;
  logic [LANES-1:0]   be_base;

  assign disp_eff  = (req_size == 2'b11) ? {req_disp[15:2], 2'b00} : req_disp;
  assign ea        = req_base + {{(XLEN-16){disp_eff[15]}}, disp_eff};
  assign sz_l2     = (XLEN == 32 && req_size == 2'b11) ? 2'b10 : req_size;
  assign off_raw   = ea[OFF_W-1:0];
  assign size_mask = OFF_W'((32'd1 << sz_l2) - 32'd1);
  assign off       = off_raw & ~size_mask;

  always_comb begin
    be_base = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      be_base[i] = (i < (32'd1 << sz_l2));
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(off_raw & size_mask);
`endif

  // Right-justify the addressed lanes, then truncate and extend to XLEN
  logic [XLEN-1:0]    ld_sh, ld_ext;
  logic               ld_msb;
  int unsigned        ld_nbits;

  assign ld_sh    = mem_rdata >> {off_q, 3'b000};
  assign ld_nbits = 32'd8 << sz_q;

  always_comb begin
    ld_msb = 1'b0;
    ld_ext = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == ld_nbits - 32'd1) ld_msb = ld_sh[i];
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      ld_ext[i] = (i < ld_nbits) ? ld_sh[i] : (signed_q & ld_msb);
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    store_d      = store_q;
    signed_d     = signed_q;
    sz_d         = sz_q;
    rd_d         = rd_q;
    off_d        = off_q;
    req_ready_d  = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_be_d     = '0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_rd_d    = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          signed_d = req_signed;
          sz_d     = sz_l2;
          rd_d     = req_rd;
          off_d    = off;
          cnt_d    = '0;
`ifdef LSU_ALIGN_CHECK_EN
          if (misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = req_rd;
            resp_err_d   = 1'b1;
          end else begin
`else
          begin
`endif
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = {ea[XLEN-1:OFF_W], OFF_W'(0)};
            mem_be_d    = be_base << off;
            mem_wdata_d = req_wdata << {off, 3'b000};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ACCESS: begin
        if (mem_ack) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_we_d    = ~store_q;
          resp_rd_d    = rd_q;
          resp_data_d  = store_q ? '0 : ld_ext;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt + CNT_W'(1);
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we;
          mem_addr_d  = mem_addr;
          mem_be_d    = mem_be;
          mem_wdata_d = mem_wdata;
        end
      end

      RESP: begin
        state_d     = IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      sz_q       <= 2'b00;
      rd_q       <= '0;
      off_q      <= '0;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rd    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      store_q    <= store_d;
      signed_q   <= signed_d;
      sz_q       <= sz_d;
      rd_q       <= rd_d;
      off_q      <= off_d;
      req_ready  <= req_ready_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_we    <= resp_we_d;
      resp_rd    <= resp_rd_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=64, TIMEOUT=16) with a response scoreboard queue.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_store, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_base, req_wdata;
  logic [15:0] req_disp;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        resp_valid, resp_we, resp_err;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t sbq[$];

  load_store_unit #(.XLEN(64), .TAG_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_base(req_base),
    .req_disp(req_disp), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ack_cyc: cycle (mem_req starts in cycle 1) in which mem_ack is driven; 0 = never.
  // req_cyc: expected number of mem_req-high cycles; resp_cyc: expected cycle of resp_valid.
  task automatic run_txn(input string name, input bit st, input logic [1:0] sz, input bit sg,
                         input logic [63:0] base, input logic [15:0] disp, input logic [63:0] wd,
                         input logic [4:0] rd, input int ack_cyc, input logic [63:0] rdata,
                         input logic [63:0] e_addr, input logic [7:0] e_be, input logic [63:0] e_wdata,
                         input logic [63:0] e_data, input bit e_err, input int req_cyc, input int resp_cyc);
    int    nreq = 0;
    int    got  = 0;
    resp_t e;
    @(negedge clk);
    chk({name, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_base = base; req_disp = disp; req_wdata = wd; req_rd = rd;
    sbq.push_back('{we: !st && !e_err, rd: rd, data: e_data, err: e_err});
    @(negedge clk);
    req_valid = 1'b0;
    if (req_cyc > 0) begin
      chk({name, ".mem_we"},    64'(mem_we), 64'(st));
      chk({name, ".mem_addr"},  mem_addr, e_addr);
      chk({name, ".mem_be"},    64'(mem_be), 64'(e_be));
      chk({name, ".mem_wdata"}, mem_wdata, e_wdata);
    end
    for (int c = 1; c <= 64 && got == 0; c++) begin
      if (resp_valid) begin
        got = c;
      end else begin
        if (mem_req) nreq++;
        if (c == ack_cyc) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    chk({name, ".resp_cycle"}, 64'(got), 64'(resp_cyc));
    chk({name, ".req_cycles"}, 64'(nreq), 64'(req_cyc));
    if (got != 0) begin
      chk({name, ".sb_nonempty"}, 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk({name, ".resp_we"},   64'(resp_we), 64'(e.we));
        chk({name, ".resp_rd"},   64'(resp_rd), 64'(e.rd));
        chk({name, ".resp_data"}, resp_data, e.data);
        chk({name, ".resp_err"},  64'(resp_err), 64'(e.err));
      end
      @(negedge clk);
      chk({name, ".pulse_end"}, 64'(resp_valid), 64'd0);
      chk({name, ".ready_back"}, 64'(req_ready), 64'd1);
    end else begin
      sbq.delete();
    end
  endtask

  initial begin
    int seen;
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_base = '0; req_disp = '0; req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready",  64'(req_ready), 64'd1);
    chk("rst.mem_req",    64'(mem_req), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.mem_be",     64'(mem_be), 64'd0);
    chk("rst.resp_data",  resp_data, 64'd0);
    rst = 1'b1;

    // mem_ack while idle must not start anything
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack.ready", 64'(req_ready), 64'd1);
    chk("idle_ack.resp",  64'(resp_valid), 64'd0);

    run_txn("ld_dword", 0, 2'b11, 0, 64'h100, 16'h0008, 64'h0, 5'd5, 3, 64'h1122334455667788,
            64'h108, 8'hFF, 64'h0, 64'h1122334455667788, 0, 3, 4);
    run_txn("ld_sbyte", 0, 2'b00, 1, 64'h200, 16'hFFFF, 64'h0, 5'd7, 1, 64'h8000000000000000,
            64'h1F8, 8'h80, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1, 2);
    run_txn("ld_ubyte", 0, 2'b00, 0, 64'h200, 16'hFFFF, 64'h0, 5'd8, 1, 64'h8000000000000000,
            64'h1F8, 8'h80, 64'h0, 64'h80, 0, 1, 2);
    run_txn("st_half", 1, 2'b01, 0, 64'h10, 16'h0002, 64'hABCD, 5'd9, 2, 64'hFFFFFFFFFFFFFFFF,
            64'h10, 8'h0C, 64'h00000000ABCD0000, 64'h0, 0, 2, 3);
    run_txn("timeout", 0, 2'b11, 0, 64'h0, 16'h0000, 64'h0, 5'd10, 0, 64'h0,
            64'h0, 8'hFF, 64'h0, 64'h0, 1, 16, 17);
    run_txn("ack_last", 0, 2'b11, 0, 64'h0, 16'h0000, 64'h0, 5'd11, 16, 64'hDEADBEEF01234567,
            64'h0, 8'hFF, 64'h0, 64'hDEADBEEF01234567, 0, 16, 17);
    run_txn("ld_shalf", 0, 2'b01, 1, 64'h100, 16'h0006, 64'h0, 5'd12, 2, 64'h8001000000000000,
            64'h100, 8'hC0, 64'h0, 64'hFFFFFFFFFFFF8001, 0, 2, 3);
    run_txn("ld_sword_pos", 0, 2'b10, 1, 64'h20, 16'h0004, 64'h0, 5'd13, 1, 64'h7FFFFFFF00000000,
            64'h20, 8'hF0, 64'h0, 64'h000000007FFFFFFF, 0, 1, 2);
    run_txn("st_byte_wrap", 1, 2'b00, 0, 64'h0, 16'h8000, 64'h5A, 5'd14, 1, 64'h0,
            64'hFFFFFFFFFFFF8000, 8'h01, 64'h5A, 64'h0, 0, 1, 2);
`ifdef LSU_ALIGN_CHECK_EN
    run_txn("ld_word_mis", 0, 2'b10, 0, 64'h100, 16'h0002, 64'h0, 5'd15, 1, 64'hCAFEBABE87654321,
            64'h0, 8'h00, 64'h0, 64'h0, 1, 0, 1);
    run_txn("ld_ds_mis", 0, 2'b11, 0, 64'h1000, 16'h0007, 64'h0, 5'd16, 1, 64'h0123456789ABCDEF,
            64'h0, 8'h00, 64'h0, 64'h0, 1, 0, 1);
`else
    run_txn("ld_word_mis", 0, 2'b10, 0, 64'h100, 16'h0002, 64'h0, 5'd15, 1, 64'hCAFEBABE87654321,
            64'h100, 8'h0F, 64'h0, 64'h87654321, 0, 1, 2);
    run_txn("ld_ds_mis", 0, 2'b11, 0, 64'h1000, 16'h0007, 64'h0, 5'd16, 1, 64'h0123456789ABCDEF,
            64'h1000, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 0, 1, 2);
`endif

    // Reset in the middle of an access: no response may follow
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b11; req_base = 64'h300; req_disp = 16'h0; req_rd = 5'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.mem_req_before", 64'(mem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.mem_req",   64'(mem_req), 64'd0);
    chk("rst_mid.req_ready", 64'(req_ready), 64'd1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rst_mid.no_resp", 64'(seen), 64'd0);

    run_txn("after_rst", 0, 2'b11, 0, 64'h100, 16'h0008, 64'h0, 5'd5, 3, 64'h1122334455667788,
            64'h108, 8'hFF, 64'h0, 64'h1122334455667788, 0, 3, 4);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
